// File: rtl/register_file_sb.sv
// Register file with a per-register pending scoreboard.
// Register 0 reads as zero, ignores writes and never becomes pending.
// Optional macro RF_BYPASS_EN forwards same-cycle writeback data to the
// read ports and masks busy for the register being written.
module register_file_sb #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned AW   = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            RegWrite,
  input  logic [AW-1:0]   A3,
  input  logic [XLEN-1:0] WD3,
  input  logic [AW-1:0]   A1,
  input  logic [AW-1:0]   A2,
  output logic [XLEN-1:0] RD1,
  output logic [XLEN-1:0] RD2,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  output logic            busy1,
  output logic            busy2,
  output logic [AW:0]     pend_cnt,
  output logic            wb_err
);

  localparam int unsigned DEPTH = 2 ** AW;
  localparam int unsigned CW    = AW + 1;

  logic [XLEN-1:0]  regs_q [DEPTH];
  logic [XLEN-1:0]  regs_d [DEPTH];
  logic [DEPTH-1:0] pending_q, pending_d;
  logic [CW-1:0]    pend_cnt_q, pend_cnt_d;
  logic             wb_err_q, wb_err_d;
  logic             wr_en, iss_en;

  // Qualified write and issue strobes; register 0 is never a target.
  assign wr_en  = RegWrite && (A3 != '0);
  assign iss_en = issue_valid && (issue_rd != '0);

  // Next state: write data, clear-then-set pending (issue wins), sticky error, popcount.
  always_comb begin
    regs_d     = regs_q;
    pending_d  = pending_q;
    wb_err_d   = wb_err_q;
    pend_cnt_d = '0;
    if (wr_en) begin
      regs_d[A3]    = WD3;
      pending_d[A3] = 1'b0;
      if (!pending_q[A3]) begin
        wb_err_d = 1'b1;
      end
    end
    if (iss_en) begin
      pending_d[issue_rd] = 1'b1;
    end
    for (int unsigned i = 0; i < DEPTH; i++) begin
      pend_cnt_d = pend_cnt_d + CW'(pending_d[i]);
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      pending_q  <= '0;
      pend_cnt_q <= '0;
      wb_err_q   <= 1'b0;
    end else begin
      regs_q     <= regs_d;
      pending_q  <= pending_d;
      pend_cnt_q <= pend_cnt_d;
      wb_err_q   <= wb_err_d;
    end
  end

  assign pend_cnt = pend_cnt_q;
  assign wb_err   = wb_err_q;

  // Read port 1: stored value and pending bit, optionally bypassed from writeback.
  always_comb begin
    RD1   = regs_q[A1];
    busy1 = pending_q[A1] && (A1 != '0);
`ifdef RF_BYPASS_EN
    if (rst_n && wr_en && (A3 == A1)) begin
      RD1   = WD3;
      busy1 = 1'b0;
    end
`endif
  end

  // Read port 2: same behaviour as port 1 for A2.
  always_comb begin
    RD2   = regs_q[A2];
    busy2 = pending_q[A2] && (A2 != '0);
`ifdef RF_BYPASS_EN
    if (rst_n && wr_en && (A3 == A2)) begin
      RD2   = WD3;
      busy2 = 1'b0;
    end
`endif
  end

endmodule
